// File: rtl/fpu_pkg.sv
// Shared FPU issue definitions: opcode map, responder state encoding, opcode class helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_pkg;

    // Special-function unit opcodes
    localparam logic [5:0] OP_SIN   = 6'h21;
    localparam logic [5:0] OP_COS   = 6'h22;
    localparam logic [5:0] OP_EXP2  = 6'h23;
    localparam logic [5:0] OP_LOG2  = 6'h2B;
    localparam logic [5:0] OP_RCP   = 6'h2C;
    localparam logic [5:0] OP_RSQRT = 6'h2D;

    // Divide / square-root unit opcodes
    localparam logic [5:0] OP_DIV    = 6'h24;
    localparam logic [5:0] OP_SQRT_F = 6'h25;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SFU_RUN = 2'd1,
        DS_RUN  = 2'd2
    } fsm_state_e;

    function automatic logic is_sfu_op(input logic [5:0] op);
        return (op == OP_SIN) || (op == OP_COS) || (op == OP_EXP2) ||
               (op == OP_LOG2) || (op == OP_RCP) || (op == OP_RSQRT);
    endfunction

    function automatic logic is_ds_op(input logic [5:0] op);
        return (op == OP_DIV) || (op == OP_SQRT_F);
    endfunction

endpackage

// File: rtl/sfu_ds_responder_lat_counter.sv
// Run-cycle counter: load to 1 on issue, clear on completion, else increment while running.
// Latency: tc is a combinational compare of the registered count against lat.
// Backpressure: en low (pipe stall) freezes the count.
module lat_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] lat,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins over clear, clear wins over increment; stall holds.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (load)     cnt_d = CNT_W'(1);
            else if (clr) cnt_d = '0;
            else if (inc) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == lat);

endmodule

// File: rtl/sfu_ds_responder.sv
// Captures SFU/DS issues, holds operands for the unit, counts its fixed latency, registers the result.
// Latency: busy for LAT cycles after the issue edge, result_valid one cycle later.
// Backpressure: LSreq=1 freezes all state; strobes seen during a stall are dropped, not queued.
module sfu_ds_responder
    import fpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SFU_LAT = 2,
    parameter int DS_LAT  = 5,
    parameter int CNT_W   = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LSreq,
    input  logic [5:0]        opcode,
    input  logic              sfu_en,
    input  logic              DS_en,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [DATA_W-1:0] sfu_res_i,
    input  logic [DATA_W-1:0] ds_res_i,
    output logic [DATA_W-1:0] op_a_q,
    output logic [DATA_W-1:0] op_b_q,
    output logic [5:0]        op_q,
    output logic              sfu_busy,
    output logic              ds_busy,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid,
    output logic              result_src,
    output logic              issue_err
);

    fsm_state_e        state_q, state_d;
    logic [DATA_W-1:0] op_a_d, op_b_d;
    logic [5:0]        op_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              result_src_q, result_src_d;
    logic              issue_err_q, issue_err_d;
    logic              cnt_load, cnt_clr, cnt_tc;
    logic [CNT_W-1:0]  cnt_lat;

    assign cnt_lat = (state_q == DS_RUN) ? CNT_W'(DS_LAT) : CNT_W'(SFU_LAT);

    lat_counter #(.CNT_W(CNT_W)) u_lat_counter (
        .clk   (Clk),
        .rst_n (Reset),
        .en    (!LSreq),
        .load  (cnt_load),
        .clr   (cnt_clr),
        .inc   (state_q != IDLE),
        .lat   (cnt_lat),
        .tc    (cnt_tc)
    );

    // Issue acceptance/rejection, completion and result capture; everything holds under stall.
    always_comb begin
        state_d        = state_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        op_d           = op_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        result_src_d   = result_src_q;
        issue_err_d    = 1'b0;
        cnt_load       = 1'b0;
        cnt_clr        = 1'b0;
        if (!LSreq) begin
            result_valid_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (DS_en && is_ds_op(opcode)) begin
                        state_d  = DS_RUN;
                        op_a_d   = operand_a;
                        op_b_d   = operand_b;
                        op_d     = opcode;
                        cnt_load = 1'b1;
                    end else if (DS_en && sfu_en) begin
                        // DS has priority; a rejected DS issue is not retried as SFU.
                        issue_err_d = 1'b1;
                    end else if (sfu_en && is_sfu_op(opcode)) begin
                        state_d  = SFU_RUN;
                        op_a_d   = operand_a;
                        op_b_d   = operand_b;
                        op_d     = opcode;
                        cnt_load = 1'b1;
                    end else if (sfu_en || DS_en) begin
                        issue_err_d = 1'b1;
                    end
                end
                SFU_RUN, DS_RUN: begin
                    issue_err_d = sfu_en || DS_en;
                    if (cnt_tc) begin
                        state_d        = IDLE;
                        result_d       = (state_q == DS_RUN) ? ds_res_i : sfu_res_i;
                        result_src_d   = (state_q == DS_RUN);
                        result_valid_d = 1'b1;
                        cnt_clr        = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, held operands and result registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q        <= IDLE;
            op_a_q         <= '0;
            op_b_q         <= '0;
            op_q           <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            result_src_q   <= 1'b0;
            issue_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            op_q           <= op_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            result_src_q   <= result_src_d;
            issue_err_q    <= issue_err_d;
        end
    end

    assign sfu_busy     = (state_q == SFU_RUN);
    assign ds_busy      = (state_q == DS_RUN);
    assign result_o     = result_q;
    assign result_valid = result_valid_q;
    assign result_src   = result_src_q;
    assign issue_err    = issue_err_q;

endmodule

// File: tb/tb_sfu_ds_responder.sv
// Directed bench for sfu_ds_responder: stimulus pushes expected results, a monitor pops on each new result_valid.
// Latency: cycle checks sampled 1 time unit after the rising edge; monitor samples on the falling edge.
// Backpressure: LSreq stall windows are driven directly by the stimulus.
module tb_sfu_ds_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        LSreq;
    logic [5:0]  opcode;
    logic        sfu_en, DS_en;
    logic [31:0] operand_a, operand_b, sfu_res_i, ds_res_i;
    logic [31:0] op_a_q, op_b_q, result_o;
    logic [5:0]  op_q;
    logic        sfu_busy, ds_busy, result_valid, result_src, issue_err;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q[$];   // {src, data}
    logic        prev_vld = 1'b0;

    sfu_ds_responder dut (
        .Clk(Clk), .Reset(Reset), .LSreq(LSreq), .opcode(opcode),
        .sfu_en(sfu_en), .DS_en(DS_en), .operand_a(operand_a), .operand_b(operand_b),
        .sfu_res_i(sfu_res_i), .ds_res_i(ds_res_i), .op_a_q(op_a_q), .op_b_q(op_b_q),
        .op_q(op_q), .sfu_busy(sfu_busy), .ds_busy(ds_busy), .result_o(result_o),
        .result_valid(result_valid), .result_src(result_src), .issue_err(issue_err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each rising result_valid must match the oldest expected result.
    always @(negedge Clk) begin
        if (result_valid && !prev_vld) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got 0x%08h src %0d with nothing expected", result_o, result_src);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("mon_result", result_o, e[31:0]);
                check("mon_src", {31'd0, result_src}, {31'd0, e[32]});
            end
        end
        prev_vld = result_valid;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Present one strobe cycle and return just after the sampling edge.
    task automatic issue(input logic ds, input logic sfu, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        DS_en = ds; sfu_en = sfu; opcode = op; operand_a = a; operand_b = b;
        step();
        DS_en = 1'b0; sfu_en = 1'b0;
    endtask

    // Busy for n cycles, then the completion cycle with the given result.
    task automatic run_check(input int n, input logic ds, input logic [31:0] res);
        for (int i = 0; i < n; i++) begin
            check("busy_run", {30'd0, ds_busy, sfu_busy}, ds ? 32'd2 : 32'd1);
            check("no_valid_run", {31'd0, result_valid}, 32'd0);
            step();
        end
        check("busy_done", {30'd0, ds_busy, sfu_busy}, 32'd0);
        check("valid_done", {31'd0, result_valid}, 32'd1);
        check("result_done", result_o, res);
        check("src_done", {31'd0, result_src}, {31'd0, ds});
    endtask

    initial begin
        Reset = 1'b0; LSreq = 1'b0; opcode = '0; sfu_en = 1'b0; DS_en = 1'b0;
        operand_a = '0; operand_b = '0; sfu_res_i = '0; ds_res_i = '0;
        #2;
        check("rst_outputs", {op_q, 26'd0} | op_a_q | op_b_q | result_o |
              {27'd0, sfu_busy, ds_busy, result_valid, result_src, issue_err}, 32'd0);
        step(); step();
        Reset = 1'b1;
        step();

        // DS divide, no stall
        ds_res_i = 32'h3FC90FDB;
        exp_q.push_back({1'b1, 32'h3FC90FDB});
        issue(1'b1, 1'b0, 6'h24, 32'h40490FDB, 32'h40000000);
        check("cap_a", op_a_q, 32'h40490FDB);
        check("cap_b", op_b_q, 32'h40000000);
        check("cap_op", {26'd0, op_q}, 32'h24);
        run_check(5, 1'b1, 32'h3FC90FDB);
        step();
        check("valid_one_cycle", {31'd0, result_valid}, 32'd0);
        check("hold_after_done", op_a_q, 32'h40490FDB);

        // SFU then back-to-back DS issued in the valid cycle
        sfu_res_i = 32'h12345678;
        exp_q.push_back({1'b0, 32'h12345678});
        issue(1'b0, 1'b1, 6'h22, 32'h00000011, 32'h00000022);
        run_check(2, 1'b0, 32'h12345678);
        ds_res_i = 32'hCAFEF00D;
        exp_q.push_back({1'b1, 32'hCAFEF00D});
        issue(1'b1, 1'b0, 6'h25, 32'h00000033, 32'h00000044);
        check("b2b_valid_clear", {31'd0, result_valid}, 32'd0);
        check("b2b_err", {31'd0, issue_err}, 32'd0);
        run_check(5, 1'b1, 32'hCAFEF00D);
        step();

        // Stall 3 cycles at DS count 2, then stall while valid
        ds_res_i = 32'h11112222;
        exp_q.push_back({1'b1, 32'h11112222});
        issue(1'b1, 1'b0, 6'h24, 32'hAAAA0001, 32'hBBBB0002);
        step();
        LSreq = 1'b1;
        sfu_en = 1'b1; opcode = 6'h27;
        step();
        sfu_en = 1'b0;
        check("stall_no_err", {31'd0, issue_err}, 32'd0);
        step(); step();
        check("stall_busy", {30'd0, ds_busy, sfu_busy}, 32'd2);
        LSreq = 1'b0;
        run_check(4, 1'b1, 32'h11112222);
        LSreq = 1'b1;
        step();
        check("stall_valid_hold1", {31'd0, result_valid}, 32'd1);
        step();
        check("stall_valid_hold2", {31'd0, result_valid}, 32'd1);
        LSreq = 1'b0;
        step();
        check("stall_valid_drop", {31'd0, result_valid}, 32'd0);

        // Rejections in IDLE
        issue(1'b0, 1'b1, 6'h27, 32'hDEAD0000, 32'hDEAD0001);
        check("rej_sfu_err", {31'd0, issue_err}, 32'd1);
        check("rej_sfu_hold", op_a_q, 32'hAAAA0001);
        check("rej_sfu_idle", {30'd0, ds_busy, sfu_busy}, 32'd0);
        step();
        check("rej_err_pulse", {31'd0, issue_err}, 32'd0);
        issue(1'b1, 1'b0, 6'h21, 32'hDEAD0002, 32'hDEAD0003);
        check("rej_ds_err", {31'd0, issue_err}, 32'd1);
        check("rej_ds_hold", {26'd0, op_q}, 32'h24);
        check("rej_ds_holdb", op_b_q, 32'hBBBB0002);
        step();

        // SFU strobe during DS_RUN is rejected, DS result unaffected
        ds_res_i = 32'h0BADBEEF;
        sfu_res_i = 32'h99999999;
        exp_q.push_back({1'b1, 32'h0BADBEEF});
        issue(1'b1, 1'b0, 6'h24, 32'h00000100, 32'h00000200);
        issue(1'b0, 1'b1, 6'h22, 32'h00000300, 32'h00000400);
        check("run_rej_err", {31'd0, issue_err}, 32'd1);
        check("run_rej_hold", op_a_q, 32'h00000100);
        run_check(4, 1'b1, 32'h0BADBEEF);
        step();

        // Both strobes with a DS opcode: DS wins, no error
        ds_res_i = 32'h76543210;
        exp_q.push_back({1'b1, 32'h76543210});
        issue(1'b1, 1'b1, 6'h25, 32'h00000500, 32'h00000600);
        check("both_err", {31'd0, issue_err}, 32'd0);
        run_check(5, 1'b1, 32'h76543210);
        step();

        // Reset at DS count 3 aborts with no result
        ds_res_i = 32'h55555555;
        issue(1'b1, 1'b0, 6'h24, 32'h00000700, 32'h00000800);
        step(); step();
        Reset = 1'b0;
        #1;
        check("mid_rst_outputs", {op_q, 26'd0} | op_a_q | op_b_q | result_o |
              {27'd0, sfu_busy, ds_busy, result_valid, result_src, issue_err}, 32'd0);
        step();
        Reset = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("post_rst_no_valid", {29'd0, result_valid, ds_busy, sfu_busy}, 32'd0);
            step();
        end
        sfu_res_i = 32'hA5A5A5A5;
        exp_q.push_back({1'b0, 32'hA5A5A5A5});
        issue(1'b0, 1'b1, 6'h2B, 32'h00000900, 32'h00000A00);
        run_check(2, 1'b0, 32'hA5A5A5A5);
        step(); step();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sfu_ds_responder.md
Name: sfu_ds_responder

Overview:
- Execution-side responder to the instruction synchronizer's `sfu_en` / `DS_en` issue strobes.
- On each accepted issue it:
  - captures the opcode and operands;
  - holds them stable for the SFU or DS (divide/sqrt) unit;
  - counts the fixed unit latency;
  - registers the unit result with a one-cycle valid toward writeback.
- Sits between the FPU issue logic and the SFU/DS datapaths.
- Freezes completely whenever a load/store request stalls the pipe.

Parameters:
- DATA_W, 32, operand/result width.
- SFU_LAT, 2, SFU latency in run cycles (opcodes 0x21, 0x22, 0x23, 0x2B, 0x2C, 0x2D).
- DS_LAT, 5, DS latency in run cycles (opcodes 0x24, 0x25).
- CNT_W, 3, counter width; must satisfy 2^CNT_W > max(SFU_LAT, DS_LAT).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous reset, active-low.
- LSreq  in  1  load/store stall; 1 freezes all state.
- opcode  in  6  opcode presented with the issue strobe.
- sfu_en  in  1  SFU issue strobe.
- DS_en  in  1  DS issue strobe.
- operand_a  in  DATA_W  first operand at issue.
- operand_b  in  DATA_W  second operand at issue.
- sfu_res_i  in  DATA_W  SFU combinational result of held operands.
- ds_res_i  in  DATA_W  DS combinational result of held operands.
- op_a_q  out  DATA_W  held operand A to the units.
- op_b_q  out  DATA_W  held operand B to the units.
- op_q  out  6  held opcode to the units.
- sfu_busy  out  1  SFU operation in flight.
- ds_busy  out  1  DS operation in flight.
- result_o  out  DATA_W  registered result.
- result_valid  out  1  result_o valid.
- result_src  out  1  0 = SFU, 1 = DS, for the last completed result.
- issue_err  out  1  one-cycle pulse: issue rejected.

Behaviour:
- Reset (Reset = 0, async): state IDLE, count 0, and every output 0 (op_a_q, op_b_q, op_q, result_o, result_valid, result_src, sfu_busy, ds_busy, issue_err).
- States: IDLE, SFU_RUN, DS_RUN. sfu_busy = (state == SFU_RUN); ds_busy = (state == DS_RUN); both are registered-state decodes.
- Stall: any edge with LSreq = 1 updates nothing. State, count, held regs, result_o, result_valid and result_src all hold; issue_err is forced 0. Strobes presented while LSreq = 1 are ignored, not queued.
- IDLE, LSreq = 0:
  - DS_en = 1 with opcode in {0x24, 0x25}: capture operands and opcode, count <= 1, go to DS_RUN.
  - Otherwise, sfu_en = 1 with opcode in the SFU set: capture, count <= 1, go to SFU_RUN.
  - DS_en has priority if both strobes are high.
  - A strobe with a non-matching opcode, or both strobes high with DS rejected: stay IDLE, issue_err = 1 next cycle.
- RUN states, LSreq = 0:
  - If count == LAT: result_o <= unit result (sfu_res_i or ds_res_i), result_src <= unit, result_valid <= 1, count <= 0, go to IDLE.
  - Otherwise count <= count + 1.
- Any strobe in a RUN state is rejected: issue_err pulses and the in-flight operation is unaffected.
- Latency: for an issue sampled at edge T with no stalls, busy is high for cycles T+1..T+LAT and result_valid is high for exactly one cycle, starting at T+LAT+1. Each cycle of LSreq = 1 extends this by one cycle.
- result_valid:
  - Clears on the next non-stalled edge unless a new completion occurs on that edge.
  - If stalled, it stays high until the first non-stalled edge.
- Back-to-back: an issue is accepted in the cycle result_valid is high, because state is already IDLE.
- Held operands and opcode change only on an accepted issue and stay valid after completion.
- Reset mid-operation aborts with no result_valid.

Decomposition:
- Shared package `fpu_pkg`:
  - opcode localparams (OP_SQRT_*, OP_DIV = 0x24/0x25, the SFU set);
  - state enum typedef {IDLE, SFU_RUN, DS_RUN}, `logic [1:0]` under SYNTHESIS;
  - functions `is_sfu_op()` and `is_ds_op()`, also used by inst_sync.
- One sub-module, `lat_counter` (load, enable = !LSreq, terminal-count compare against a latency input), is natural. The FSM and capture registers stay at top level.

Test Plan:
- DS issue: opcode 0x24, A = 0x40490FDB, B = 0x40000000, ds_res_i = 0x3FC90FDB, no stall → ds_busy high 5 cycles, then result_valid for 1 cycle with result_o = 0x3FC90FDB and result_src = 1.
- SFU issue: opcode 0x22 with sfu_res_i = 0x12345678 → sfu_busy 2 cycles, valid at T+3, result_src = 0. Then a DS issue in the valid cycle is accepted, and ds_busy rises at the next cycle.
- Stall: LSreq = 1 for 3 cycles during DS count 2 → valid arrives at T+9. Also, LSreq = 1 while result_valid = 1 → valid held until LSreq drops, then exactly 1 more cycle.
- Rejection cases, each giving issue_err for 1 cycle with held regs unchanged:
  - sfu_en with opcode 0x27;
  - DS_en with opcode 0x21;
  - sfu_en during DS_RUN, which must also leave ds_busy and the final result_o unaffected.
- Both strobes with opcode 0x25 → DS path taken, no issue_err.
- Reset asserted at DS count 3 → all outputs 0 asynchronously; after release, no result_valid appears and the FSM accepts a new SFU issue normally.
